serial_fir: RTL and testbench
=============================

# serial_fir

Time-multiplexed (serial) direct-form FIR filter: one shared multiply-accumulate unit computes each output over N_TAPS consecutive clock cycles. It uses a fixed 21-tap symmetric low-pass coefficient ROM. It sits in the sample-rate datapath, accepting 16-bit signed samples with a valid strobe and presenting a registered full-precision 37-bit result. While a computation is in progress, input samples are ignored.

## Interface
- N_TAPS, 21, number of taps; the ROM is defined for 21 only.
- DATA_WIDTH, 16, signed input sample width.
- COEF_WIDTH, 16, signed coefficient width.
- OUT_WIDTH, 37, signed output width (DATA_WIDTH+COEF_WIDTH+ceil(log2 N_TAPS)).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset; name kept per codebase).
- x_in  in  DATA_WIDTH  signed input sample.
- x_valid  in  1  sample strobe; sampled only when idle.
- y_out  out  OUT_WIDTH  signed filter output, registered, holds until next result.

## Operation
- Coefficients h[k], k=0..20, symmetric with h[20-k]=h[k]:
  - h0..h10 = -64, -128, -160, 0, 384, 1024, 1792, 2560, 3200, 3584, 3712.
  - Sum (DC gain) = 28096.
- Delay line x[0..20] holds signed samples, with x[0] the newest.
- State IDLE:
  - If x_valid=1, shift the line (x[k]<=x[k-1], x[0]<=x_in).
  - Clear the accumulator, set idx<=0, and go to MAC.
  - If x_valid=0, hold.
- State MAC, once per cycle:
  - acc <= acc + x[idx]*h[idx], then idx++.
  - When idx=20, load y_out <= acc + x[20]*h[20] and return to IDLE.
- Result: y_out = Σ x[k]·h[k] over the line contents at acceptance.
- Arithmetic:
  - The product is full-precision signed, DATA_WIDTH+COEF_WIDTH = 32 bits.
  - It is sign-extended to OUT_WIDTH and accumulated with no rounding, truncation or saturation.
  - Overflow cannot occur at the default widths.
- x_valid/x_in are ignored in MAC: samples are dropped, not queued, and the line does not shift.
- No output-valid strobe: y_out changes only on result load.

## Timing
- Reset (rst_n=1 at an edge):
  - y_out=0, delay line all 0, acc=0, idx=0, state IDLE.
  - Reset takes priority over everything.
  - Reset during MAC aborts the computation; y_out stays 0.
- Sample accepted at edge E0 (IDLE and x_valid=1).
- MAC terms are summed on edges E1..E21; y_out is updated at E21 (latency 21 cycles from acceptance).
- State is IDLE after E21. The earliest next acceptance is E22.
- With x_valid held high continuously, one sample is accepted every 22 cycles and y_out updates every 22 cycles.
- x_valid high for a single cycle during IDLE suffices; there is no handshake back to the source.
- After the first release of reset, the first 20 results include zeros from the cleared line (startup transient).

## Test plan
- Reset: assert rst_n for 2 cycles with x_valid=1 and x_in=1234. Required: y_out=0 throughout and 1 cycle after release, with no acceptance during reset.
- Impulse: accept x=1, then 21 samples of 0, each offered on IDLE. Required: successive y_out values are h0..h20 (-64, -128, -160, 0, 384, …, 3712, …, -64), then 0.
- DC: 25 accepted samples of 1000. Required: from the 21st result onward, y_out=28,096,000. With -32768 instead: y_out=-920,649,728.
- Latency/throughput: x_valid held high. Required: acceptances exactly 22 cycles apart, and y_out changes exactly 21 cycles after each acceptance.
- Busy drop: after an accepted impulse of 1, drive x_valid=1 with x_in=500 during cycles E1..E21 only, then offer 0 in IDLE. Required: the second result is -128 (500 never entered the line).
- Mid-operation reset: accept 1000, assert reset at E10. Required: y_out=0 and the line is cleared. The next accepted 1000 yields y_out=-64000.

Source files
------------

// File: rtl/serial_fir.sv
// ---------------------------------------------------------------------------
// serial_fir
//
// Time-multiplexed direct-form FIR filter. A single shared multiply-accumulate
// unit walks the 21-entry delay line one tap per clock, so each output takes
// N_TAPS cycles to compute. The coefficient set is a fixed symmetric 21-tap
// low-pass (DC gain 28096). Samples offered while a computation is running
// are dropped; the delay line only shifts on acceptance.
//
// Ports
//   clk      : single clock, all logic on the rising edge
//   rst_n    : synchronous reset, ACTIVE HIGH despite the name (1 = reset)
//   x_in     : signed input sample, DATA_WIDTH bits
//   x_valid  : sample strobe, only looked at while idle
//   y_out    : signed full-precision result, registered, holds between results
// ---------------------------------------------------------------------------
module serial_fir #(
    parameter int N_TAPS     = 21,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int OUT_WIDTH  = 37
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic                         x_valid,
    output logic signed [OUT_WIDTH-1:0]  y_out
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam int IDX_WIDTH  = $clog2(N_TAPS);
    localparam int HALF_TAPS  = (N_TAPS + 1) / 2;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_TAPS - 1);

    // First half (h0..h10) of the symmetric impulse response; the second
    // half is mirrored when the full table is built below.
    localparam logic signed [COEF_WIDTH-1:0] COEF_HALF [HALF_TAPS] = '{
        COEF_WIDTH'(-64),
        COEF_WIDTH'(-128),
        COEF_WIDTH'(-160),
        COEF_WIDTH'(0),
        COEF_WIDTH'(384),
        COEF_WIDTH'(1024),
        COEF_WIDTH'(1792),
        COEF_WIDTH'(2560),
        COEF_WIDTH'(3200),
        COEF_WIDTH'(3584),
        COEF_WIDTH'(3712)
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    state_t                          state_reg;
    state_t                          state_next;

    logic signed [DATA_WIDTH-1:0]    x_line_reg [N_TAPS];
    logic signed [OUT_WIDTH-1:0]     acc_reg;
    logic signed [OUT_WIDTH-1:0]     acc_next;
    logic        [IDX_WIDTH-1:0]     idx_reg;
    logic        [IDX_WIDTH-1:0]     idx_next;
    logic signed [OUT_WIDTH-1:0]     y_reg;

    logic signed [COEF_WIDTH-1:0]    coef_rom [N_TAPS];
    logic signed [DATA_WIDTH-1:0]    tap_sample;
    logic signed [COEF_WIDTH-1:0]    coef_sel;
    logic signed [PROD_WIDTH-1:0]    product;
    logic signed [OUT_WIDTH-1:0]     product_ext;

    // FSM decoded controls
    logic                            accept;
    logic                            mac_en;
    logic                            mac_last;

    // -----------------------------------------------------------------------
    // Coefficient ROM: full 21-entry table mirrored from the half table.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_coef_rom
            localparam int SRC = (gi <= N_TAPS / 2) ? gi : (N_TAPS - 1 - gi);
            assign coef_rom[gi] = COEF_HALF[SRC];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (x_valid) begin
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output decode
    // -----------------------------------------------------------------------
    always_comb begin
        accept   = 1'b0;
        mac_en   = 1'b0;
        mac_last = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                accept = x_valid;
            end
            ST_MAC: begin
                mac_en   = 1'b1;
                mac_last = (idx_reg == LAST_IDX);
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // MAC datapath. The operands are sign-extended to the product width
    // before multiplying so the full signed product is kept, then the
    // product is sign-extended again to the accumulator width. No rounding
    // or saturation: the 37-bit accumulator cannot overflow for 21 taps.
    // -----------------------------------------------------------------------
    assign tap_sample  = x_line_reg[idx_reg];
    assign coef_sel    = coef_rom[idx_reg];
    assign product     = PROD_WIDTH'(tap_sample) * PROD_WIDTH'(coef_sel);
    assign product_ext = OUT_WIDTH'(product);

    always_comb begin
        acc_next = acc_reg;
        idx_next = idx_reg;
        if (accept) begin
            acc_next = '0;
            idx_next = '0;
        end else if (mac_en) begin
            acc_next = acc_reg + product_ext;
            idx_next = mac_last ? '0 : idx_reg + IDX_WIDTH'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers. The delay line shifts only on acceptance, so
    // samples arriving during a computation never reach it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x_line_reg[k] <= '0;
            end
            acc_reg <= '0;
            idx_reg <= '0;
            y_reg   <= '0;
        end else begin
            if (accept) begin
                x_line_reg[0] <= x_in;
                for (int k = 1; k < N_TAPS; k++) begin
                    x_line_reg[k] <= x_line_reg[k-1];
                end
            end
            acc_reg <= acc_next;
            idx_reg <= idx_next;
            // The final tap's sum goes straight to the output register;
            // the accumulator itself is cleared on the next acceptance.
            if (mac_last) begin
                y_reg <= acc_next;
            end
        end
    end

    assign y_out = y_reg;

endmodule

// File: tb/tb_serial_fir.sv
// ---------------------------------------------------------------------------
// tb_serial_fir
//
// Self-checking bench for serial_fir. A behavioural model keeps the delay
// line as a plain array, computes each result as a dot product at the moment
// of acceptance, and tracks busy time as a simple cycle count. y_out is
// compared with the model every cycle, plus directed checks against known
// constants for impulse, DC, throughput, busy-drop and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_serial_fir;

    localparam int N_TAPS     = 21;
    localparam int DATA_WIDTH = 16;
    localparam int COEF_WIDTH = 16;
    localparam int OUT_WIDTH  = 37;
    localparam int LATENCY    = 21;

    localparam int H_HALF [11] = '{-64, -128, -160, 0, 384, 1024, 1792,
                                   2560, 3200, 3584, 3712};

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic signed [DATA_WIDTH-1:0] x_in;
    logic                         x_valid;
    logic signed [OUT_WIDTH-1:0]  y_out;

    serial_fir #(
        .N_TAPS     (N_TAPS),
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_in    (x_in),
        .x_valid (x_valid),
        .y_out   (y_out)
    );

    always #5 clk = ~clk;

    int     cmp_count = 0;
    int     err_count = 0;

    // Reference model state
    int     model_line [N_TAPS];
    longint model_y    = 0;
    longint model_pend = 0;
    int     model_busy = 0;
    int     cyc        = 0;
    int     accept_cycles [$];
    int     change_cycles [$];
    logic signed [OUT_WIDTH-1:0] prev_y = '0;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        cmp_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int coef(input int k);
        return H_HALF[(k <= 10) ? k : (N_TAPS - 1 - k)];
    endfunction

    // Shift a new sample into the model line and return the dot product.
    function automatic longint model_accept(input int x);
        longint s = 0;
        for (int k = N_TAPS - 1; k > 0; k--) model_line[k] = model_line[k-1];
        model_line[0] = x;
        for (int k = 0; k < N_TAPS; k++) s += longint'(model_line[k]) * coef(k);
        return s;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare y_out.
    task automatic cycle(input bit v, input int x, input bit r);
        rst_n   = r;
        x_valid = v;
        x_in    = DATA_WIDTH'(x);
        @(posedge clk);
        cyc++;
        if (r) begin
            for (int k = 0; k < N_TAPS; k++) model_line[k] = 0;
            model_busy = 0;
            model_y    = 0;
        end else if (model_busy == 0) begin
            if (v) begin
                model_pend = model_accept(x);
                model_busy = LATENCY;
                accept_cycles.push_back(cyc);
            end
        end else begin
            model_busy--;
            if (model_busy == 0) model_y = model_pend;
        end
        @(negedge clk);
        check_val("y_cycle", y_out, model_y);
        if (y_out !== prev_y) change_cycles.push_back(cyc);
        prev_y = y_out;
        $display("cyc %0d rst=%0b v=%0b x=%0d y=%0d", cyc, r, v, x, y_out);
    endtask

    // Offer one sample in IDLE and run until its result is loaded.
    task automatic offer(input int x, output longint res);
        cycle(1'b1, x, 1'b0);
        repeat (LATENCY) cycle(1'b0, 0, 1'b0);
        res = longint'(y_out);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint res;
        int     n_res;
        for (int k = 0; k < N_TAPS; k++) model_line[k] = 0;
        rst_n   = 1'b1;
        x_valid = 1'b0;
        x_in    = '0;

        // Reset with a sample offered: must not be accepted.
        cycle(1'b1, 1234, 1'b1);
        check_val("rst_y0", y_out, 0);
        cycle(1'b1, 1234, 1'b1);
        check_val("rst_y1", y_out, 0);
        cycle(1'b0, 0, 1'b0);
        check_val("rst_release", y_out, 0);

        // Impulse response: h0..h20 then 0.
        offer(1, res);
        check_val("impulse_0", res, coef(0));
        for (int k = 1; k < N_TAPS; k++) begin
            offer(0, res);
            check_val($sformatf("impulse_%0d", k), res, coef(k));
        end
        offer(0, res);
        check_val("impulse_tail", res, 0);

        // DC response
        for (int i = 1; i <= 25; i++) begin
            offer(1000, res);
            if (i >= 21) check_val($sformatf("dc_pos_%0d", i), res, 64'sd28096000);
        end
        for (int i = 1; i <= 25; i++) begin
            offer(-32768, res);
            if (i >= 21) check_val($sformatf("dc_neg_%0d", i), res, -64'sd920649728);
        end

        // Throughput: x_valid held high with random samples.
        cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b0);
        accept_cycles.delete();
        change_cycles.delete();
        prev_y = y_out;
        repeat (5 * (LATENCY + 1))
            cycle(1'b1, $urandom_range(1, 30000), 1'b0);
        n_res = change_cycles.size();
        check_val("tp_results", n_res, 5);
        for (int i = 0; i < n_res && i < accept_cycles.size(); i++)
            check_val($sformatf("tp_latency_%0d", i),
                      change_cycles[i] - accept_cycles[i], LATENCY);
        for (int i = 1; i < n_res; i++)
            check_val($sformatf("tp_interval_%0d", i),
                      change_cycles[i] - change_cycles[i-1], LATENCY + 1);

        // Busy drop: 500 offered during E1..E21 must never enter the line.
        cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b0);
        cycle(1'b1, 1, 1'b0);
        repeat (LATENCY) cycle(1'b1, 500, 1'b0);
        check_val("busy_first", y_out, -64);
        offer(0, res);
        check_val("busy_second", res, -128);

        // Mid-operation reset at E10 clears the line and keeps y_out at 0.
        cycle(1'b1, 1000, 1'b0);
        repeat (9) cycle(1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1);
        check_val("midrst_y", y_out, 0);
        cycle(1'b0, 0, 1'b0);
        check_val("midrst_idle", y_out, 0);
        offer(1000, res);
        check_val("midrst_next", res, -64000);

        // Random traffic with occasional resets, checked cycle by cycle.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, 65535)) - 32768,
                  ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
